// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and widths for the 4-requester arbiter
package arb_pkg;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/prio_enc4.sv
// rtl/prio_enc4.sv - combinational 4-to-2 priority encoder, MSB highest
module prio_enc4
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] in_vec,
    output logic [ID_W-1:0] idx,
    output logic            valid
);

    always_comb begin
        idx   = 2'd0;
        valid = 1'b1;
        casez (in_vec)
            4'b1???: idx = 2'd3;
            4'b01??: idx = 2'd2;
            4'b001?: idx = 2'd1;
            4'b0001: idx = 2'd0;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/arb4_rr_ctrl.sv
// rtl/arb4_rr_ctrl.sv - 4-requester arbiter, fixed or round-robin, with hold timeout
module arb4_rr_ctrl
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            rr_en,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t          state;
    logic [7:0]      hold_cnt;
    logic [ID_W-1:0] ptr;

    logic            owner_req;
    logic            timeout;
    logic [NREQ-1:0] others;
    logic [NREQ-1:0] cand;
    logic [ID_W-1:0] off;
    logic [7:0]      dbl_sh;
    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] rev;
    logic [NREQ-1:0] enc_in;
    logic [ID_W-1:0] enc_idx;
    logic            enc_valid;
    logic [ID_W-1:0] win_id;
    logic [NREQ-1:0] win_onehot;

    always_comb begin
        owner_req = req[gnt_id];
        timeout   = (hold_cnt == HOLD_LAST);
        others    = req & ~gnt;
        // On a timeout with competitors the owner is excluded; otherwise req is used as-is.
        cand      = (state == BUSY && owner_req && others != 4'b0000) ? others : req;
        off       = ptr + 2'd1;
        dbl_sh    = {cand, cand} >> off;
        rot       = dbl_sh[3:0];
        rev       = {rot[0], rot[1], rot[2], rot[3]};
        enc_in    = rr_en ? rev : cand;
    end

    prio_enc4 u_enc (
        .in_vec (enc_in),
        .idx    (enc_idx),
        .valid  (enc_valid)
    );

    // Reversed encoding picks the lowest rotated index; undo the reversal and rotation.
    always_comb begin
        win_id     = rr_en ? ((2'd3 - enc_idx) + off) : enc_idx;
        win_onehot = 4'b0001 << win_id;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            hold_cnt  <= 8'd0;
            ptr       <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (enc_valid) begin
                        state     <= BUSY;
                        gnt       <= win_onehot;
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= 8'd0;
                        ptr       <= win_id;
                    end
                end
                BUSY: begin
                    if ((!owner_req && enc_valid) || (owner_req && timeout)) begin
                        state     <= BUSY;
                        gnt       <= win_onehot;
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= 8'd0;
                        ptr       <= win_id;
                    end else if (!owner_req) begin
                        state     <= IDLE;
                        gnt       <= 4'b0000;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= 8'd0;
                    end else begin
                        hold_cnt  <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
